pe_array_mc: RTL and testbench
==============================

Name: pe_array_mc

Overview:
Multi-channel successor to the single-row PE array: N_CH × N_PEs MAC grid.
- One input activation per beat is broadcast to every PE of every channel.
- Each PE holds its own per-channel weight and bias.
- An internal FSM sequences bias preload, a counted accumulation over a valid/ready activation stream, and a serial valid/ready drain of all partial sums.
- Sits between the activation buffer and the psum/output writeback path.

Parameters:
DATA_WIDTH, 8, activation width
WIDTH_WGT, 8, weight width (always signed)
PSUM_WIDTH, 32, accumulator/output width
BIAS_WIDTH, 16, bias width (signed)
N_PEs, 16, PEs per channel
N_CH, 4, parallel output channels
LEN_W, 12, beat-count width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a pass (honoured only in IDLE)
len  in  LEN_W  activation beats in this pass; latched on start
ia_sign  in  1  1 = ia signed, 0 = unsigned; latched on start
ia  in  DATA_WIDTH  activation
ia_valid  in  1  activation valid
ia_ready  out  1  activation accept
wgt_we  in  1  write weight row (IDLE only)
bias_we  in  1  write bias row (IDLE only)
wr_ch  in  clog2(N_CH)  channel targeted by wgt_we/bias_we
wgt  in  WIDTH_WGT*N_PEs  weights; PE i = slice [WIDTH_WGT*(N_PEs-i)-1 : WIDTH_WGT*(N_PEs-i-1)]
bias  in  BIAS_WIDTH*N_PEs  biases; same MSB-first slicing
relu_en  in  1  ReLU on drained data (see Optional Feature)
out_data  out  PSUM_WIDTH  drained psum
out_valid  out  1  drain word valid
out_ready  in  1  downstream accept
busy  out  1  FSM not IDLE
done  out  1  one-cycle pulse after last drain word accepted

Behaviour:
Reset:
- FSM to IDLE; all accumulators, weights and biases cleared to 0.
- ia_ready = out_valid = busy = done = 0.

Register writes:
- wgt_we/bias_we update the N_PEs entries of channel wr_ch at the clock edge, IDLE only; ignored in any other state.
- wgt_we and bias_we may both be asserted in the same cycle; both take effect.
- wr_ch >= N_CH is ignored.

FSM: IDLE -> BIAS -> ACCUM -> DRAIN -> IDLE.
- IDLE: start=1 latches len and ia_sign and goes to BIAS. A simultaneous start and wgt_we/bias_we performs the write and then starts.
- BIAS (1 cycle): acc[c][i] <= sign-extended bias[c][i]; beat counter cleared. Next state is ACCUM if len != 0, else DRAIN.
- ACCUM: ia_ready = 1. Each accepted beat (ia_valid & ia_ready) updates acc[c][i] += ext(ia) * signed(wgt[c][i]) at that edge.
  - ext(ia) is a sign-extension if ia_sign, else zero-extension; the product is formed at DATA_WIDTH+1 + WIDTH_WGT bits, then sign-extended to PSUM_WIDTH.
  - The sum wraps modulo 2^PSUM_WIDTH; there is no saturation.
  - The edge that accepts beat len moves the FSM to DRAIN. ia_ready is 0 in every other state.
- DRAIN: out_valid = 1; out_data = acc[idx], combinational from registers.
  - Order is channel-major: ch0 PE0..PE(N_PEs-1), then ch1, and so on; N_CH*N_PEs words in total.
  - idx advances only on out_valid & out_ready. out_data is stable while stalled.
  - Acceptance of the last word goes to IDLE and pulses done for one cycle on the following cycle.

Latency:
- start to first ia_ready is 2 cycles.
- Last beat accepted to out_valid is 1 cycle.
- Minimum pass length is 2 + len + N_CH*N_PEs cycles.

Other rules:
- Reset asserted mid-pass aborts immediately to the reset state. No done pulse; any partial drain is lost.
- start is ignored while busy.
- Accumulators hold their values in IDLE until the next BIAS state.

Optional Feature:
PE_ARRAY_MC_RELU_EN
- Defined: when relu_en=1, a drained word with MSB set is output as 0; when relu_en=0, the word is raw. Accumulators are never modified.
- Undefined: relu_en is ignored and out_data is always the raw accumulator.
- The port list is identical in both builds.

Decomposition:
- Package pe_array_mc_pkg holds:
  - FSM state enum (IDLE, BIAS, ACCUM, DRAIN)
  - localparam for the total drain word count
  - sign/zero-extend helper function for ia
- Sub-module pe_mac_cell (one per channel×PE): weight/bias registers, accumulator, and extended multiply-add.
- The top level holds the FSM, counters, broadcast and drain mux.

Test Plan:
1. N_CH=2, N_PEs=2, weights ch0={1,2}, ch1={-1,3}, biases 0, len=3, ia_sign=0, ia=1,2,3 -> drain 6,12,-6,18 in that order; done 1 cycle after last accept.
2. Bias {100,-50}, ia_sign=1, ia=-128 (0x80), wgt=127, len=1 -> PE0 = 100-16256 = -16156; same with ia_sign=0 -> 100+16256 = 16356.
3. len=0 -> drained words equal the sign-extended biases; ia_ready never asserted.
4. Backpressure: toggle ia_valid and out_ready randomly -> results identical to test 1; out_data held constant while out_valid & !out_ready.
5. wgt_we and start during ACCUM -> ignored (weights unchanged, no restart); reset asserted mid-DRAIN -> all outputs 0 next cycle, no done.
6. With PE_ARRAY_MC_RELU_EN, relu_en=1 on test 1 -> 6,12,0,18; without the macro -> 6,12,-6,18.

Source files
------------

// File: rtl/pe_array_mc_pkg.sv
// Shared types and helpers for the multi-channel PE array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default geometry and drain word count,
// and the activation extension helper used at the broadcast point.
package pe_array_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BIAS  = 2'd1,
    ACCUM = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_N_PES  = 16;
  // Number of words streamed out per pass for the default geometry.
  localparam int DRAIN_WORDS = DEF_N_CH * DEF_N_PES;

  // Extra MSB prepended to an activation: copies the sign bit when the pass
  // treats activations as signed, otherwise zero-extends.
  function automatic logic ia_ext_msb(input logic ia_msb, input logic ia_signed);
    return ia_signed & ia_msb;
  endfunction

endpackage

// File: rtl/pe_mac_cell.sv
// One MAC element: per-PE weight and bias registers plus a psum accumulator.
// Latency: accumulator updates at the edge where acc_en or load_bias is high.
// Backpressure: none; the parent only asserts acc_en on an accepted beat.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wgt_we, wgt_in      weight write (already qualified by the parent)
//   bias_we, bias_in    bias write (already qualified by the parent)
//   load_bias           acc <= sign-extended bias
//   acc_en              acc += ia_ext * weight
//   ia_ext              broadcast activation, already extended by one bit
//   acc                 accumulator value
module pe_mac_cell #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH_WGT  = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int BIAS_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wgt_we,
  input  logic [WIDTH_WGT-1:0]  wgt_in,
  input  logic                  bias_we,
  input  logic [BIAS_WIDTH-1:0] bias_in,
  input  logic                  load_bias,
  input  logic                  acc_en,
  input  logic [DATA_WIDTH:0]   ia_ext,
  output logic [PSUM_WIDTH-1:0] acc
);

  // Full signed product width: extended activation times signed weight.
  localparam int PW = DATA_WIDTH + 1 + WIDTH_WGT;

  logic [WIDTH_WGT-1:0]  wgt_r;
  logic [BIAS_WIDTH-1:0] bias_r;

  logic signed [PW-1:0]  ia_w;
  logic signed [PW-1:0]  wgt_w;
  logic signed [PW-1:0]  prod;
  logic [PSUM_WIDTH-1:0] prod_ext;
  logic [PSUM_WIDTH-1:0] bias_ext;

  // Both operands widened to the product width so the multiply is exact
  // and no implicit extension is left to the tools.
  assign ia_w  = {{WIDTH_WGT{ia_ext[DATA_WIDTH]}}, ia_ext};
  assign wgt_w = {{(DATA_WIDTH + 1){wgt_r[WIDTH_WGT-1]}}, wgt_r};
  assign prod  = ia_w * wgt_w;

  assign prod_ext = {{(PSUM_WIDTH - PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(PSUM_WIDTH - BIAS_WIDTH){bias_r[BIAS_WIDTH-1]}}, bias_r};

  always_ff @(posedge clk) begin
    if (reset) begin
      wgt_r  <= '0;
      bias_r <= '0;
      acc    <= '0;
    end else begin
      if (wgt_we)  wgt_r  <= wgt_in;
      if (bias_we) bias_r <= bias_in;
      // Writes are IDLE-only and load/accumulate are BIAS/ACCUM-only, so
      // these never overlap. Accumulation wraps with no saturation.
      if (load_bias)   acc <= bias_ext;
      else if (acc_en) acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/pe_array_mc.sv
// N_CH x N_PEs MAC grid: bias preload, counted accumulation, serial psum drain.
// Latency: start->ia_ready 2 cycles; last beat->out_valid 1 cycle; done 1 cycle after last drain accept.
// Backpressure: ia stream stalls on ia_valid low; drain holds out_data stable while out_ready is low.
//
// Build option: define PE_ARRAY_MC_RELU_EN to clamp negative drained words to
// zero when relu_en=1. Without it relu_en is ignored; ports are identical.
//
// Ports:
//   clk, reset                synchronous active-high reset
//   start, len, ia_sign       begin a pass (IDLE only); len/ia_sign latched
//   ia, ia_valid, ia_ready    activation stream broadcast to every PE
//   wgt_we, bias_we, wr_ch    row writes to one channel (IDLE only)
//   wgt, bias                 row data, PE0 in the most significant slice
//   relu_en                   optional clamp on drained data
//   out_data, out_valid, out_ready  channel-major psum drain
//   busy, done                FSM not IDLE / end-of-pass pulse
module pe_array_mc
  import pe_array_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH_WGT  = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int BIAS_WIDTH = 16,
  parameter int N_PEs      = DEF_N_PES,
  parameter int N_CH       = DEF_N_CH,
  parameter int LEN_W      = 12,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LEN_W-1:0]            len,
  input  logic                        ia_sign,
  input  logic [DATA_WIDTH-1:0]       ia,
  input  logic                        ia_valid,
  output logic                        ia_ready,
  input  logic                        wgt_we,
  input  logic                        bias_we,
  input  logic [CH_W-1:0]             wr_ch,
  input  logic [WIDTH_WGT*N_PEs-1:0]  wgt,
  input  logic [BIAS_WIDTH*N_PEs-1:0] bias,
  input  logic                        relu_en,
  output logic [PSUM_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int TOTAL = N_CH * N_PEs;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  state_t               state;
  logic [LEN_W-1:0]     len_q;
  logic                 sign_q;
  logic [LEN_W-1:0]     beat_cnt;
  logic [IDX_W-1:0]     idx;

  logic                 ia_accept;
  logic                 in_idle;
  logic                 load_bias;
  logic [DATA_WIDTH:0]  ia_ext;
  logic [PSUM_WIDTH-1:0] acc_all [TOTAL];
  logic [PSUM_WIDTH-1:0] raw;

  assign in_idle   = (state == IDLE);
  assign load_bias = (state == BIAS);
  // ia_ready is only ever high in ACCUM, so this is the accepted-beat strobe.
  assign ia_accept = ia_valid & ia_ready;
  assign ia_ext    = {ia_ext_msb(ia[DATA_WIDTH-1], sign_q), ia};

  // Sequencer. Handshake outputs are registered alongside the state so they
  // change only on the edge that enters or leaves the owning state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      sign_q    <= 1'b0;
      beat_cnt  <= '0;
      idx       <= '0;
      ia_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            sign_q <= ia_sign;
            busy   <= 1'b1;
            state  <= BIAS;
          end
        end
        BIAS: begin
          beat_cnt <= '0;
          idx      <= '0;
          if (len_q != '0) begin
            state    <= ACCUM;
            ia_ready <= 1'b1;
          end else begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end
        end
        ACCUM: begin
          if (ia_accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == len_q - 1'b1) begin
              state     <= DRAIN;
              ia_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == IDX_W'(TOTAL - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              idx       <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MAC grid. A wr_ch value with no matching channel simply selects nothing.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic ch_sel;
    assign ch_sel = in_idle && (wr_ch == CH_W'(c));

    for (genvar i = 0; i < N_PEs; i++) begin : g_pe
      pe_mac_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .WIDTH_WGT  (WIDTH_WGT),
        .PSUM_WIDTH (PSUM_WIDTH),
        .BIAS_WIDTH (BIAS_WIDTH)
      ) u_cell (
        .clk       (clk),
        .reset     (reset),
        .wgt_we    (wgt_we & ch_sel),
        .wgt_in    (wgt[WIDTH_WGT*(N_PEs-i)-1 -: WIDTH_WGT]),
        .bias_we   (bias_we & ch_sel),
        .bias_in   (bias[BIAS_WIDTH*(N_PEs-i)-1 -: BIAS_WIDTH]),
        .load_bias (load_bias),
        .acc_en    (ia_accept),
        .ia_ext    (ia_ext),
        .acc       (acc_all[c*N_PEs + i])
      );
    end
  end

  // Channel-major drain mux straight from the accumulators; idx only moves
  // on an accepted word, so the output is stable across a stall.
  assign raw = acc_all[idx];

`ifdef PE_ARRAY_MC_RELU_EN
  assign out_data = (relu_en && raw[PSUM_WIDTH-1]) ? '0 : raw;
`else
  logic unused_relu_en;
  assign unused_relu_en = relu_en;
  assign out_data = raw;
`endif

endmodule

// File: tb/tb_pe_array_mc.sv
// Directed self-checking bench for pe_array_mc on a 2x2 grid.
// Latency: checks start->ready, last beat->valid and last accept->done timing.
// Backpressure: exercises random ia_valid/out_ready stalls and drain hold.
module tb_pe_array_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] len;
  logic        ia_sign;
  logic [7:0]  ia;
  logic        ia_valid;
  logic        ia_ready;
  logic        wgt_we;
  logic        bias_we;
  logic [0:0]  wr_ch;
  logic [15:0] wgt;
  logic [31:0] bias;
  logic        relu_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  // Per-pass observations filled in by run_pass.
  logic [31:0] got [8];
  logic [7:0]  ia_vec [4];
  int n_got, first_rdy, first_vld, last_beat_it, last_acc_it, done_it;
  int done_cnt, rdy_seen, hold_chk, hold_err, timed_out, busy_after;

  always #5 clk = ~clk;

  pe_array_mc #(.N_PEs(2), .N_CH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .ia_sign(ia_sign),
    .ia(ia), .ia_valid(ia_valid), .ia_ready(ia_ready),
    .wgt_we(wgt_we), .bias_we(bias_we), .wr_ch(wr_ch), .wgt(wgt), .bias(bias),
    .relu_en(relu_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic write_row(input logic ch, input logic [15:0] w, input logic [31:0] b,
                           input logic ww, input logic bw);
    wr_ch = ch; wgt = w; bias = b; wgt_we = ww; bias_we = bw;
    @(negedge clk);
    wgt_we = 1'b0; bias_we = 1'b0;
  endtask

  // Starts a pass at the current negedge, feeds ia_vec, collects drain words.
  // inject: on the first ACCUM cycle pulse start+wgt_we with no beat offered.
  task automatic run_pass(input int n, input logic sgn, input logic bp, input logic inject);
    int beat;
    logic stall_pend;
    logic [31:0] stall_dat;
    beat = 0; stall_pend = 1'b0; stall_dat = '0;
    n_got = 0; first_rdy = -1; first_vld = -1; last_beat_it = -1; last_acc_it = -1;
    done_it = -1; done_cnt = 0; rdy_seen = 0; hold_chk = 0; hold_err = 0; timed_out = 0;
    start = 1'b1; len = 12'(n); ia_sign = sgn;
    @(negedge clk);
    start = 1'b0; wgt_we = 1'b0; bias_we = 1'b0;
    if (ia_ready) rdy_seen++;
    for (int it = 0; it < 400 && done_cnt == 0; it++) begin
      @(negedge clk);
      if (ia_ready) rdy_seen++;
      if (ia_ready && first_rdy < 0) first_rdy = it;
      if (out_valid && first_vld < 0) first_vld = it;
      if (done) begin done_cnt++; done_it = it; end
      if (stall_pend && out_valid) begin
        hold_chk++;
        if (out_data !== stall_dat) hold_err++;
      end
      if (inject && it == first_rdy) begin
        start = 1'b1; wgt_we = 1'b1; wr_ch = 1'b0; wgt = 16'h3232;
        ia_valid = 1'b0; out_ready = 1'b1;
      end else begin
        start = 1'b0; wgt_we = 1'b0;
        ia_valid = (beat < n) && (!bp || ($urandom_range(0, 1) == 1));
        ia = ia_vec[beat < 4 ? beat : 0];
        out_ready = !bp || ($urandom_range(0, 1) == 1);
      end
      if (ia_valid && ia_ready) begin beat++; last_beat_it = it; end
      if (out_valid && out_ready) begin
        if (n_got < 8) got[n_got] = out_data;
        n_got++;
        last_acc_it = it;
      end
      stall_pend = out_valid && !out_ready;
      stall_dat  = out_data;
    end
    if (done_cnt == 0) timed_out = 1;
    ia_valid = 1'b0; out_ready = 1'b1; start = 1'b0; wgt_we = 1'b0;
    @(negedge clk);
    if (done) done_cnt++;
    busy_after = busy ? 1 : 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (ia_ready !== 1'b0) begin fails++; $display("FAIL reset_ia_ready got %b exp 0", ia_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] exp [4];
    exp[0] = 32'd6; exp[1] = 32'd12; exp[2] = -32'sd6; exp[3] = 32'd18;
    write_row(1'b0, {8'd1, 8'd2}, 32'd0, 1'b1, 1'b1);
    write_row(1'b1, {8'hFF, 8'd3}, 32'd0, 1'b1, 1'b1);
    ia_vec[0] = 8'd1; ia_vec[1] = 8'd2; ia_vec[2] = 8'd3;
    run_pass(3, 1'b0, 1'b0, 1'b0);
    tests++; if (timed_out != 0) begin fails++; $display("FAIL basic_timeout got %0d exp 0", timed_out); end
    tests++; if (n_got != 4) begin fails++; $display("FAIL basic_count got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp[k]) begin fails++; $display("FAIL basic_word%0d got %h exp %h", k, got[k], exp[k]); end
    end
    tests++; if (first_rdy != 0) begin fails++; $display("FAIL basic_start_to_ready got %0d exp 0 (2 cycles)", first_rdy); end
    tests++; if (first_vld != last_beat_it + 1) begin fails++; $display("FAIL basic_beat_to_valid got %0d exp %0d", first_vld, last_beat_it + 1); end
    tests++; if (done_it != last_acc_it + 1) begin fails++; $display("FAIL basic_done_timing got %0d exp %0d", done_it, last_acc_it + 1); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); end
    tests++; if (busy_after != 0) begin fails++; $display("FAIL basic_busy_after got %0d exp 0", busy_after); end
  endtask

  task automatic test_sign();
    logic [31:0] exp_s [4];
    logic [31:0] exp_u [4];
    exp_s[0] = -32'sd16156; exp_s[1] = -32'sd16306; exp_s[2] = 32'd128;     exp_s[3] = -32'sd384;
    exp_u[0] = 32'd16356;   exp_u[1] = 32'd16206;   exp_u[2] = -32'sd128;  exp_u[3] = 32'd384;
    write_row(1'b0, {8'd127, 8'd127}, {16'd100, 16'hFFCE}, 1'b1, 1'b1);
    ia_vec[0] = 8'h80;
    run_pass(1, 1'b1, 1'b0, 1'b0);
    tests++; if (n_got != 4) begin fails++; $display("FAIL sign_s_count got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp_s[k]) begin fails++; $display("FAIL sign_s_word%0d got %h exp %h", k, got[k], exp_s[k]); end
    end
    run_pass(1, 1'b0, 1'b0, 1'b0);
    tests++; if (n_got != 4) begin fails++; $display("FAIL sign_u_count got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp_u[k]) begin fails++; $display("FAIL sign_u_word%0d got %h exp %h", k, got[k], exp_u[k]); end
    end
  endtask

  task automatic test_len_zero();
    logic [31:0] exp [4];
    exp[0] = 32'd100; exp[1] = -32'sd50; exp[2] = 32'd7; exp[3] = -32'sd3;
    // Bias write for ch1 lands on the same edge as start.
    wr_ch = 1'b1; bias = {16'd7, 16'hFFFD}; bias_we = 1'b1;
    run_pass(0, 1'b0, 1'b0, 1'b0);
    tests++; if (n_got != 4) begin fails++; $display("FAIL len0_count got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp[k]) begin fails++; $display("FAIL len0_word%0d got %h exp %h", k, got[k], exp[k]); end
    end
    tests++; if (rdy_seen != 0) begin fails++; $display("FAIL len0_ia_ready got %0d cycles exp 0", rdy_seen); end
    tests++; if (first_vld != 0) begin fails++; $display("FAIL len0_first_valid got %0d exp 0", first_vld); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [4];
    exp[0] = 32'd6; exp[1] = 32'd12; exp[2] = -32'sd6; exp[3] = 32'd18;
    write_row(1'b0, {8'd1, 8'd2}, 32'd0, 1'b1, 1'b1);
    write_row(1'b1, 16'd0, 32'd0, 1'b0, 1'b1);
    ia_vec[0] = 8'd1; ia_vec[1] = 8'd2; ia_vec[2] = 8'd3;
    run_pass(3, 1'b0, 1'b1, 1'b0);
    tests++; if (timed_out != 0) begin fails++; $display("FAIL bp_timeout got %0d exp 0", timed_out); end
    tests++; if (n_got != 4) begin fails++; $display("FAIL bp_count got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp[k]) begin fails++; $display("FAIL bp_word%0d got %h exp %h", k, got[k], exp[k]); end
    end
    tests++; if (hold_chk == 0) begin fails++; $display("FAIL bp_no_stalls got %0d exp >0", hold_chk); end
    tests++; if (hold_err != 0) begin fails++; $display("FAIL bp_hold got %0d changes exp 0", hold_err); end
  endtask

  task automatic test_relu();
    logic [31:0] exp [4];
    exp[0] = 32'd6; exp[1] = 32'd12; exp[3] = 32'd18;
`ifdef PE_ARRAY_MC_RELU_EN
    exp[2] = 32'd0;
`else
    exp[2] = -32'sd6;
`endif
    relu_en = 1'b1;
    run_pass(3, 1'b0, 1'b0, 1'b0);
    relu_en = 1'b0;
    tests++; if (n_got != 4) begin fails++; $display("FAIL relu_count got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp[k]) begin fails++; $display("FAIL relu_word%0d got %h exp %h", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_ignore_and_abort();
    logic [31:0] exp [4];
    int late;
    exp[0] = 32'd6; exp[1] = 32'd12; exp[2] = -32'sd6; exp[3] = 32'd18;
    run_pass(3, 1'b0, 1'b0, 1'b1);
    tests++; if (n_got != 4) begin fails++; $display("FAIL inject_count got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp[k]) begin fails++; $display("FAIL inject_word%0d got %h exp %h", k, got[k], exp[k]); end
    end
    tests++; if (busy_after != 0) begin fails++; $display("FAIL inject_restart busy got %0d exp 0", busy_after); end

    // Abort mid-drain.
    start = 1'b1; len = 12'd1; ia_sign = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); ia_valid = 1'b1; ia = 8'd1; out_ready = 1'b0;
    @(negedge clk); ia_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL abort_in_drain out_valid got %b exp 1", out_valid); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_out_valid got %b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
    tests++; if (ia_ready !== 1'b0) begin fails++; $display("FAIL abort_ia_ready got %b exp 0", ia_ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done got %b exp 0", done); end
    tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL abort_out_data got %h exp 0", out_data); end
    reset = 1'b0; out_ready = 1'b1;
    late = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || out_valid) late++;
    end
    tests++; if (late != 0) begin fails++; $display("FAIL abort_late_activity got %0d exp 0", late); end

    // Reset cleared weights and biases: a fresh pass drains zeros.
    ia_vec[0] = 8'd5;
    run_pass(1, 1'b0, 1'b0, 1'b0);
    tests++; if (n_got != 4) begin fails++; $display("FAIL cleared_count got %0d exp 4", n_got); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== 32'd0) begin fails++; $display("FAIL cleared_word%0d got %h exp 0", k, got[k]); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; ia_sign = 1'b0; ia = '0; ia_valid = 1'b0;
    wgt_we = 1'b0; bias_we = 1'b0; wr_ch = '0; wgt = '0; bias = '0; relu_en = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_sign();
    test_len_zero();
    test_backpressure();
    test_relu();
    test_ignore_and_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
